// File: rtl/des_mem_pkg.sv
// rtl/des_mem_pkg.sv - shared widths, state encoding and write-strobe levels for the DES memory sequencer
package des_mem_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 64;
  localparam int MEM_DEPTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    COLLECT,
    WRITE,
    DONE
  } state_e;

  localparam logic WR_ACTIVE = 1'b0;
  localparam logic WR_IDLE   = 1'b1;

endpackage

// File: rtl/des_mem_sequencer.sv
// rtl/des_mem_sequencer.sv - walks a run of blocks: memory port 0 -> DES core -> memory port 1
// One block in flight at a time; every output is decoded from registered state.
module des_mem_sequencer #(
  parameter int ADDR_W = des_mem_pkg::ADDR_W,
  parameter int DATA_W = des_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   blk_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_en,
  output logic              mem_wr0,
  output logic [ADDR_W-1:0] mem_add0,
  input  logic [DATA_W-1:0] mem_data0_out,
  output logic              mem_wr1,
  output logic [ADDR_W-1:0] mem_add1,
  output logic [DATA_W-1:0] mem_data1_in,
  output logic              des_in_valid,
  input  logic              des_in_ready,
  output logic [DATA_W-1:0] des_in_data,
  input  logic              des_out_valid,
  output logic              des_out_ready,
  input  logic [DATA_W-1:0] des_out_data
);
  import des_mem_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, idx_q, idx_d;
  logic [DATA_W-1:0] blk_q, blk_d, res_q, res_d;
  logic              err_q, err_d;
  logic              cnt_ok;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  // Legal run length is 1 .. 2**ADDR_W blocks.
  assign cnt_ok  = (blk_count != '0) && (blk_count <= {1'b1, {ADDR_W{1'b0}}});
  assign idx_inc = idx_q + 1'b1;
  assign rd_addr = src_q + idx_q[ADDR_W-1:0];
  assign wr_addr = dst_q + idx_q[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    res_d   = res_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (cnt_ok) begin
            state_d = FETCH;
            src_d   = src_base;
            dst_d   = dst_base;
            cnt_d   = blk_count;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH:   state_d = WAIT;
      WAIT: begin
        blk_d   = mem_data0_out;
        state_d = SEND;
      end
      SEND:    if (des_in_ready) state_d = COLLECT;
      COLLECT: begin
        if (des_out_valid) begin
          res_d   = des_out_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == cnt_q) ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Address/data buses are forced to zero outside the state that owns them.
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign mem_en        = busy;
  assign mem_wr0       = WR_IDLE;
  assign mem_add0      = (state_q == FETCH) ? rd_addr : '0;
  assign mem_wr1       = (state_q == WRITE) ? WR_ACTIVE : WR_IDLE;
  assign mem_add1      = (state_q == WRITE) ? wr_addr : '0;
  assign mem_data1_in  = (state_q == WRITE) ? res_q : '0;
  assign des_in_valid  = (state_q == SEND);
  assign des_in_data   = (state_q == SEND) ? blk_q : '0;
  assign des_out_ready = (state_q == COLLECT);

endmodule
